// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: MIPS opcode/funct encodings,
// the destination descriptor and the destination/overflow decode helper.
package alu_pkg;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (inst[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Writeback target: wr=1 means one of the two architectural registers
    // is written, sel picks reg_a (0) or reg_b (1).
    typedef struct packed {
        logic wr;
        logic sel;
    } dest_t;

    // Decode result: destination plus whether the ALU overflow flag applies.
    typedef struct packed {
        dest_t dest;
        logic  ovf_check;
    } decode_t;

    // Map an instruction word to its writeback target. Destinations other
    // than register index 0 or 1 do not exist in this stage and are dropped.
    function automatic decode_t decode_dest(input logic [31:0] inst);
        decode_t    d;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] idx;
        logic       has_dest;
        logic       ovf;
        op       = inst[31:26];
        fn       = inst[5:0];
        idx      = 5'd0;
        has_dest = 1'b0;
        ovf      = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB: begin
                        has_dest = 1'b1;
                        idx      = inst[15:11];
                        ovf      = 1'b1;
                    end
                    FN_ADDU, FN_SUBU, FN_SLL, FN_SLLV, FN_SRL, FN_SRLV,
                    FN_SRA, FN_SRAV, FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU: begin
                        has_dest = 1'b1;
                        idx      = inst[15:11];
                    end
                    default: begin
                        has_dest = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                has_dest = 1'b1;
                idx      = inst[20:16];
                ovf      = 1'b1;
            end
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LW: begin
                has_dest = 1'b1;
                idx      = inst[20:16];
            end
            default: begin
                // beq, bne, sw and unknown opcodes never write back
                has_dest = 1'b0;
            end
        endcase
        d.dest.wr   = has_dest && (idx[4:1] == 4'd0);
        d.dest.sel  = idx[0];
        d.ovf_check = ovf;
        return d;
    endfunction

endpackage

// File: rtl/alu_inst_fifo.sv
// Instruction FIFO for the ALU issue stage: DEPTH x 32-bit, single push and
// pop per cycle, synchronous flush. Head word reads as zero when empty.
module alu_inst_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    input  logic        flush,
    output logic [31:0] head_data,
    output logic        full,
    output logic        empty
);
    import alu_pkg::*;

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          wr_en_s;
    logic          rd_en_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == '0);
    assign wr_en_s   = push && !full && !flush;
    assign rd_en_s   = pop && !empty && !flush;
    assign head_data = empty ? 32'd0 : mem_r[rd_ptr_r];

    // Storage array: write the tail slot on an accepted push
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; flush and reset both return to empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: queues instructions, presents the head plus reg_a/reg_b
// to a combinational ALU and writes the result back on the issuing edge.
// Optional build macro ALU_ISSUE_STATS_EN adds issue/overflow counters.
module alu_issue_stage #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_inst,
    output logic        in_ready,
    input  logic        flush,
    input  logic        stall,
    input  logic        load_en,
    input  logic        load_sel,
    input  logic [31:0] load_data,
    output logic [31:0] alu_inst,
    output logic [31:0] alu_reg_a,
    output logic [31:0] alu_reg_b,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
`ifdef ALU_ISSUE_STATS_EN
    output logic [31:0] stat_issued,
    output logic [31:0] stat_ovf,
`endif
    output logic        issue,
    output logic        exc_ovf
);
    import alu_pkg::*;

    logic        full_s;
    logic        empty_s;
    logic [31:0] head_s;
    logic        push_s;
    decode_t     dec_s;
    logic        ovf_hit_s;
    logic        wb_ok_s;
    logic        wb_a_s;
    logic        wb_b_s;
    logic [31:0] reg_a_r;
    logic [31:0] reg_b_r;
    logic        exc_ovf_r;
    logic        unused_flags_s;

    assign in_ready = !full_s && !flush;
    assign push_s   = in_valid && in_ready;
    assign issue    = !empty_s && !stall && !flush;

    alu_inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (in_inst),
        .pop       (issue),
        .flush     (flush),
        .head_data (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign alu_inst  = head_s;
    assign alu_reg_a = reg_a_r;
    assign alu_reg_b = reg_b_r;
    assign exc_ovf   = exc_ovf_r;

    // Only the overflow flag matters to this stage
    assign unused_flags_s = &{1'b0, alu_flags[1:0]};

    assign dec_s     = decode_dest(head_s);
    assign ovf_hit_s = issue && dec_s.ovf_check && alu_flags[2];
    assign wb_ok_s   = issue && dec_s.dest.wr && !ovf_hit_s;
    assign wb_a_s    = wb_ok_s && !dec_s.dest.sel;
    assign wb_b_s    = wb_ok_s && dec_s.dest.sel;

    // Architectural registers: external load beats writeback to the same register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_a_r <= 32'd0;
            reg_b_r <= 32'd0;
        end else begin
            if (load_en && !load_sel) begin
                reg_a_r <= load_data;
            end else if (wb_a_s) begin
                reg_a_r <= alu_result;
            end else begin
                reg_a_r <= reg_a_r;
            end
            if (load_en && load_sel) begin
                reg_b_r <= load_data;
            end else if (wb_b_s) begin
                reg_b_r <= alu_result;
            end else begin
                reg_b_r <= reg_b_r;
            end
        end
    end

    // Overflow exception pulse, one cycle after the offending issue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exc_ovf_r <= 1'b0;
        end else begin
            exc_ovf_r <= ovf_hit_s;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_issued_r;
    logic [31:0] stat_ovf_r;

    assign stat_issued = stat_issued_r;
    assign stat_ovf    = stat_ovf_r;

    // Free-running issue and overflow counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issued_r <= 32'd0;
            stat_ovf_r    <= 32'd0;
        end else begin
            if (issue) begin
                stat_issued_r <= stat_issued_r + 32'd1;
            end else begin
                stat_issued_r <= stat_issued_r;
            end
            if (exc_ovf_r) begin
                stat_ovf_r <= stat_ovf_r + 32'd1;
            end else begin
                stat_ovf_r <= stat_ovf_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage (DEPTH=4).
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        flush;
    logic        stall;
    logic        load_en;
    logic        load_sel;
    logic [31:0] load_data;
    logic [31:0] alu_inst;
    logic [31:0] alu_reg_a;
    logic [31:0] alu_reg_b;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;
    logic        issue;
    logic        exc_ovf;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_ovf;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_issued = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_inst    (in_inst),
        .in_ready   (in_ready),
        .flush      (flush),
        .stall      (stall),
        .load_en    (load_en),
        .load_sel   (load_sel),
        .load_data  (load_data),
        .alu_inst   (alu_inst),
        .alu_reg_a  (alu_reg_a),
        .alu_reg_b  (alu_reg_b),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
`ifdef ALU_ISSUE_STATS_EN
        .stat_issued(stat_issued),
        .stat_ovf   (stat_ovf),
`endif
        .issue      (issue),
        .exc_ovf    (exc_ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        in_valid = 1'b1;
        in_inst  = w;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic load(input logic sel, input logic [31:0] d);
        load_en   = 1'b1;
        load_sel  = sel;
        load_data = d;
        cyc();
        load_en   = 1'b0;
    endtask

    // Expect the head to issue this cycle; supply the ALU answer
    task automatic do_issue(input string tag, input logic [31:0] w,
                            input logic [31:0] res, input logic [2:0] fl);
        alu_result = res;
        alu_flags  = fl;
        #1;
        check_eq({tag, "_issue"}, {31'd0, issue}, 32'd1);
        check_eq({tag, "_inst"}, alu_inst, w);
        exp_issued++;
        cyc();
        alu_result = 32'd0;
        alu_flags  = 3'd0;
    endtask

    logic [31:0] t_inst [7] = '{32'h20000001, 32'h00010021, 32'h00011020, 32'hAC000000,
                                32'h8C010000, 32'h10000000, 32'h00010022};
    logic [31:0] t_res  [7] = '{32'h80000000, 32'h12345678, 32'h0000DEAD, 32'h00000055,
                                32'h00000099, 32'h00000077, 32'h00000005};
    logic [2:0]  t_fl   [7] = '{3'b110, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [31:0] t_a    [7] = '{32'h7FFFFFFF, 32'h12345678, 32'h12345678, 32'h12345678,
                                32'h12345678, 32'h12345678, 32'h00000005};
    logic [31:0] t_b    [7] = '{32'd12, 32'd12, 32'd12, 32'd12,
                                32'h99, 32'h99, 32'h99};
    logic        t_ovf  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'd0; flush = 1'b0; stall = 1'b0;
        load_en = 1'b0; load_sel = 1'b0; load_data = 32'd0;
        alu_result = 32'd0; alu_flags = 3'd0;

        // Reset state
        cyc();
        rst_n = 1'b1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_issue", {31'd0, issue}, 32'd0);
        check_eq("rst_reg_a", alu_reg_a, 32'd0);
        check_eq("rst_reg_b", alu_reg_b, 32'd0);
        check_eq("rst_inst", alu_inst, 32'd0);
        check_eq("rst_exc", {31'd0, exc_ovf}, 32'd0);

        // Basic add rd=1: 5 + 7 -> reg_b
        load(1'b0, 32'd5);
        load(1'b1, 32'd7);
        push(32'h00010820);
        check_eq("add_opa", alu_reg_a, 32'd5);
        check_eq("add_opb", alu_reg_b, 32'd7);
        do_issue("add", 32'h00010820, 32'd12, 3'b000);
        check_eq("add_wb_b", alu_reg_b, 32'd12);
        check_eq("add_keep_a", alu_reg_a, 32'd5);
        check_eq("add_idle", {31'd0, issue}, 32'd0);

        // Decode table: overflow, non-checked flag, discarded dest, no-wb ops
        load(1'b0, 32'h7FFFFFFF);
        for (int i = 0; i < 7; i++) begin
            push(t_inst[i]);
            check_eq($sformatf("tbl%0d_exc_pre", i), {31'd0, exc_ovf}, 32'd0);
            do_issue($sformatf("tbl%0d", i), t_inst[i], t_res[i], t_fl[i]);
            check_eq($sformatf("tbl%0d_exc", i), {31'd0, exc_ovf}, {31'd0, t_ovf[i]});
            check_eq($sformatf("tbl%0d_a", i), alu_reg_a, t_a[i]);
            check_eq($sformatf("tbl%0d_b", i), alu_reg_b, t_b[i]);
        end

        // Fill under stall: 5 pushes, only 4 accepted
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_inst  = 32'h10000001 + 32'(i);
            #1;
            check_eq($sformatf("fill%0d_ready", i), {31'd0, in_ready}, (i < 4) ? 32'd1 : 32'd0);
            cyc();
        end
        in_valid = 1'b0;
        stall    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) check_eq("full_pop_ready", {31'd0, in_ready}, 32'd0);
            if (i == 1) check_eq("after_pop_ready", {31'd0, in_ready}, 32'd1);
            do_issue($sformatf("drain%0d", i), 32'h10000001 + 32'(i), 32'd0, 3'b000);
        end
        check_eq("drain_empty_issue", {31'd0, issue}, 32'd0);
        check_eq("drain_empty_inst", alu_inst, 32'd0);
        check_eq("drain_keep_a", alu_reg_a, 32'd5);

        // Back-to-back dependent adds with a push overlapping the first pop
        stall = 1'b1;
        push(32'h00010820);
        push(32'h00010020);
        stall    = 1'b0;
        in_valid = 1'b1;
        in_inst  = 32'h10000009;
        check_eq("b2b_opb0", alu_reg_b, 32'h99);
        do_issue("b2b0", 32'h00010820, 32'h9E, 3'b000);
        in_valid = 1'b0;
        check_eq("b2b_opb1", alu_reg_b, 32'h9E);
        do_issue("b2b1", 32'h00010020, 32'hA3, 3'b000);
        check_eq("b2b_a", alu_reg_a, 32'hA3);
        do_issue("b2b2", 32'h10000009, 32'd0, 3'b000);
        check_eq("b2b_empty", {31'd0, issue}, 32'd0);

        // Flush with a simultaneous push
        stall = 1'b1;
        push(32'h10000011);
        push(32'h10000012);
        push(32'h10000013);
        stall    = 1'b0;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = 32'h00010820;
        alu_result = 32'hFFFFFFFF;
        #1;
        check_eq("flush_ready", {31'd0, in_ready}, 32'd0);
        check_eq("flush_issue", {31'd0, issue}, 32'd0);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("postflush_issue", {31'd0, issue}, 32'd0);
        check_eq("postflush_inst", alu_inst, 32'd0);
        check_eq("postflush_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        alu_result = 32'd0;
        check_eq("postflush_issue2", {31'd0, issue}, 32'd0);
        check_eq("postflush_a", alu_reg_a, 32'hA3);
        check_eq("postflush_b", alu_reg_b, 32'h9E);

        // Load colliding with writeback
        push(32'h00010820);
        load_en = 1'b1; load_sel = 1'b1; load_data = 32'h0000CAFE;
        do_issue("coll_b", 32'h00010820, 32'h1111, 3'b000);
        load_en = 1'b0;
        check_eq("coll_b_val", alu_reg_b, 32'h0000CAFE);
        check_eq("coll_b_a", alu_reg_a, 32'hA3);
        push(32'h00010020);
        load_en = 1'b1; load_sel = 1'b1; load_data = 32'h0000BEEF;
        do_issue("coll_x", 32'h00010020, 32'h2222, 3'b000);
        load_en = 1'b0;
        check_eq("coll_x_a", alu_reg_a, 32'h2222);
        check_eq("coll_x_b", alu_reg_b, 32'h0000BEEF);

`ifdef ALU_ISSUE_STATS_EN
        check_eq("stat_issued", stat_issued, 32'(exp_issued));
        check_eq("stat_ovf", stat_ovf, 32'd1);
`endif

        // Reset with an issuable instruction queued
        stall = 1'b1;
        push(32'h00010020);
        stall = 1'b0;
        rst_n = 1'b0;
        alu_result = 32'h0000FFFF;
        cyc();
        rst_n = 1'b1;
        alu_result = 32'd0;
        #1;
        check_eq("mrst_issue", {31'd0, issue}, 32'd0);
        check_eq("mrst_inst", alu_inst, 32'd0);
        check_eq("mrst_a", alu_reg_a, 32'd0);
        check_eq("mrst_b", alu_reg_b, 32'd0);
        check_eq("mrst_ready", {31'd0, in_ready}, 32'd1);
`ifdef ALU_ISSUE_STATS_EN
        check_eq("mrst_stat_issued", stat_issued, 32'd0);
        check_eq("mrst_stat_ovf", stat_ovf, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
